// File: rtl/nvdla_rdma_pkg.sv
// Shared types and constants for the read-DMA request engine.
// Covers the FSM states, RAM target encoding, the context-queue flag layout and the req_pd field offsets.
package nvdla_rdma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic RAM_CVIF = 1'b0;
    localparam logic RAM_MCIF = 1'b1;

    // Low bits of cq_pd; size-1 sits directly above these.
    typedef struct packed {
        logic line_end;
        logic surf_end;
        logic cube_end;
    } cq_flags_t;

    localparam int CQ_FLAGS_W   = $bits(cq_flags_t);
    localparam int REQ_ADDR_LSB = 0;

    function automatic int req_size_lsb(input int aw);
        return REQ_ADDR_LSB + aw;
    endfunction

endpackage

// File: rtl/nvdla_rdma_credit_cnt.sv
// Latency-FIFO credit pool: starts full, loses dec_val credits on an accepted request
// and regains one per returned atom.
module nvdla_rdma_credit_cnt #(
    parameter int LAT_DEPTH = 256,
    parameter int CW        = $clog2(LAT_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_en,
    input  logic [CW-1:0] dec_val,
    input  logic          inc,
    output logic [CW-1:0] credits,
    output logic          full
);

    logic [CW-1:0] credits_q, credits_d;
    logic [CW:0]   sum_w;

    always_comb begin
        sum_w     = {1'b0, credits_q} + (CW+1)'(inc) - (dec_en ? {1'b0, dec_val} : '0);
        credits_d = sum_w[CW-1:0];
    end

    // NOTE: state registers use <= so every flop samples its pre-edge inputs regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) credits_q <= CW'(LAT_DEPTH);
        else     credits_q <= credits_d;
    end

    assign credits = credits_q;
    assign full    = (credits_q == CW'(LAT_DEPTH));

    // More returns than outstanding atoms means the latency FIFO lost track.
    credit_range_a: assert property (@(posedge clk) disable iff (rst)
        sum_w <= (CW+1)'(LAT_DEPTH));

endmodule

// File: rtl/nvdla_rdma_req_engine.sv
// Read-DMA request engine: walks a surfaces x lines x atoms cube, issues line-bounded bursts
// to MCIF or CVIF, pushes one context entry per accepted request and signals done when all credits return.
module nvdla_rdma_req_engine
    import nvdla_rdma_pkg::*;
#(
    parameter int AW         = 64,
    parameter int ATOM_BYTES = 32,
    parameter int BURST_MAX  = 8,
    parameter int LAT_DEPTH  = 256,
    parameter int DIMW       = 13
) (
    input  logic                                  nvdla_core_clk,
    input  logic                                  nvdla_core_rst,
    input  logic                                  op_en,
    input  logic [AW-1:0]                         cfg_base_addr,
    input  logic [AW-1:0]                         cfg_line_stride,
    input  logic [AW-1:0]                         cfg_surf_stride,
    input  logic [DIMW-1:0]                       cfg_width,
    input  logic [DIMW-1:0]                       cfg_height,
    input  logic [DIMW-1:0]                       cfg_surfaces,
    input  logic                                  cfg_ram_type,
    output logic                                  mcif_req_valid,
    input  logic                                  mcif_req_ready,
    output logic                                  cvif_req_valid,
    input  logic                                  cvif_req_ready,
    output logic [AW+$clog2(BURST_MAX)-1:0]       req_pd,
    output logic                                  cq_valid,
    input  logic                                  cq_ready,
    output logic [$clog2(BURST_MAX)+CQ_FLAGS_W-1:0] cq_pd,
    input  logic                                  cdt_pop,
    output logic                                  busy,
    output logic                                  done,
    output logic [31:0]                           perf_read_stall
);

    localparam int BW         = $clog2(BURST_MAX);
    localparam int SW         = BW + 1;
    localparam int CW         = $clog2(LAT_DEPTH + 1);
    localparam int ATOM_SHIFT = $clog2(ATOM_BYTES);

    state_e          state_q, state_d;
    logic            ram_type_q, ram_type_d;
    logic [DIMW-1:0] width_q, width_d, height_q, height_d, surfaces_q, surfaces_d;
    logic [AW-1:0]   line_stride_q, line_stride_d, surf_stride_q, surf_stride_d;
    logic [DIMW-1:0] atom_q, atom_d, line_q, line_d, surf_q, surf_d;
    logic [AW-1:0]   line_addr_q, line_addr_d, surf_addr_q, surf_addr_d;
    logic            req_vld_q, req_vld_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BW-1:0]   size_m1_q, size_m1_d;
    cq_flags_t       flags_q, flags_d;
    logic            all_issued_q, all_issued_d;
    logic [31:0]     perf_q, perf_d;

    // Walker view: cfg inputs while IDLE (first request issues off op_en), latched state otherwise.
    logic            from_cfg;
    logic [DIMW-1:0] w_w, h_w, s_w, p_atom, p_line, p_surf;
    logic [AW-1:0]   ls_w, ss_w, p_laddr, p_saddr, addr_w;
    logic [DIMW:0]   rem_w;
    logic [SW-1:0]   size_w, cur_size;
    logic            line_end_w, surf_end_w, cube_end_w;
    logic [DIMW-1:0] nxt_atom, nxt_line, nxt_surf;
    logic [AW-1:0]   nxt_laddr, nxt_saddr;

    logic            req_ready, accept, try_issue, issue_ok, credits_full;
    logic [CW-1:0]   credits;
    logic [CW:0]     avail_w;

    assign from_cfg = (state_q == IDLE);
    assign w_w      = from_cfg ? cfg_width       : width_q;
    assign h_w      = from_cfg ? cfg_height      : height_q;
    assign s_w      = from_cfg ? cfg_surfaces    : surfaces_q;
    assign ls_w     = from_cfg ? cfg_line_stride : line_stride_q;
    assign ss_w     = from_cfg ? cfg_surf_stride : surf_stride_q;
    assign p_atom   = from_cfg ? '0              : atom_q;
    assign p_line   = from_cfg ? '0              : line_q;
    assign p_surf   = from_cfg ? '0              : surf_q;
    assign p_laddr  = from_cfg ? cfg_base_addr   : line_addr_q;
    assign p_saddr  = from_cfg ? cfg_base_addr   : surf_addr_q;

    assign rem_w      = {1'b0, w_w} - {1'b0, p_atom} + (DIMW+1)'(1);
    assign line_end_w = (rem_w <= (DIMW+1)'(BURST_MAX));
    assign size_w     = line_end_w ? SW'(rem_w) : SW'(BURST_MAX);
    assign surf_end_w = line_end_w && (p_line == h_w);
    assign cube_end_w = surf_end_w && (p_surf == s_w);
    assign addr_w     = p_laddr + (AW'(p_atom) << ATOM_SHIFT);

    assign nxt_atom  = line_end_w ? '0 : p_atom + DIMW'(size_w);
    assign nxt_line  = !line_end_w ? p_line : (surf_end_w ? '0 : p_line + DIMW'(1));
    assign nxt_surf  = surf_end_w ? p_surf + DIMW'(1) : p_surf;
    assign nxt_saddr = surf_end_w ? p_saddr + ss_w : p_saddr;
    assign nxt_laddr = !line_end_w ? p_laddr : (surf_end_w ? p_saddr + ss_w : p_laddr + ls_w);

    assign req_ready = (ram_type_q == RAM_MCIF) ? mcif_req_ready : cvif_req_ready;
    assign accept    = req_vld_q && req_ready;
    assign cur_size  = {1'b0, size_m1_q} + SW'(1);

    // Credits as they will stand after this edge, so back-to-back issue never overdraws.
    assign avail_w  = {1'b0, credits} + (CW+1)'(cdt_pop) - (accept ? (CW+1)'(cur_size) : '0);
    assign issue_ok = (avail_w >= (CW+1)'(size_w)) && cq_ready;

    nvdla_rdma_credit_cnt #(
        .LAT_DEPTH (LAT_DEPTH)
    ) u_credit (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .dec_en  (accept),
        .dec_val (CW'(cur_size)),
        .inc     (cdt_pop),
        .credits (credits),
        .full    (credits_full)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch below can leave a latch behind.
        state_d       = state_q;
        ram_type_d    = ram_type_q;
        width_d       = width_q;
        height_d      = height_q;
        surfaces_d    = surfaces_q;
        line_stride_d = line_stride_q;
        surf_stride_d = surf_stride_q;
        atom_d        = atom_q;
        line_d        = line_q;
        surf_d        = surf_q;
        line_addr_d   = line_addr_q;
        surf_addr_d   = surf_addr_q;
        req_vld_d     = req_vld_q;
        addr_d        = addr_q;
        size_m1_d     = size_m1_q;
        flags_d       = flags_q;
        all_issued_d  = all_issued_q;
        perf_d        = perf_q;
        try_issue     = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_en) begin
                    state_d       = REQ;
                    ram_type_d    = cfg_ram_type;
                    width_d       = cfg_width;
                    height_d      = cfg_height;
                    surfaces_d    = cfg_surfaces;
                    line_stride_d = cfg_line_stride;
                    surf_stride_d = cfg_surf_stride;
                    atom_d        = p_atom;
                    line_d        = p_line;
                    surf_d        = p_surf;
                    line_addr_d   = p_laddr;
                    surf_addr_d   = p_saddr;
                    all_issued_d  = 1'b0;
                    perf_d        = '0;
                    try_issue     = 1'b1;
                end
            end
            REQ: begin
                if (req_vld_q && !req_ready && (perf_q != '1)) perf_d = perf_q + 32'd1;
                if (accept) begin
                    req_vld_d = 1'b0;
                    if (flags_q.cube_end) state_d = DRAIN;
                end
                try_issue = !all_issued_q && (!req_vld_q || accept);
            end
            DRAIN: begin
                if (credits_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (try_issue && issue_ok) begin
            req_vld_d        = 1'b1;
            addr_d           = addr_w;
            size_m1_d        = BW'(size_w - SW'(1));
            flags_d.line_end = line_end_w;
            flags_d.surf_end = surf_end_w;
            flags_d.cube_end = cube_end_w;
            all_issued_d     = cube_end_w;
            atom_d           = nxt_atom;
            line_d           = nxt_line;
            surf_d           = nxt_surf;
            line_addr_d      = nxt_laddr;
            surf_addr_d      = nxt_saddr;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q       <= IDLE;
            ram_type_q    <= RAM_CVIF;
            width_q       <= '0;
            height_q      <= '0;
            surfaces_q    <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            atom_q        <= '0;
            line_q        <= '0;
            surf_q        <= '0;
            line_addr_q   <= '0;
            surf_addr_q   <= '0;
            req_vld_q     <= 1'b0;
            addr_q        <= '0;
            size_m1_q     <= '0;
            flags_q       <= '0;
            all_issued_q  <= 1'b0;
            perf_q        <= '0;
        end else begin
            state_q       <= state_d;
            ram_type_q    <= ram_type_d;
            width_q       <= width_d;
            height_q      <= height_d;
            surfaces_q    <= surfaces_d;
            line_stride_q <= line_stride_d;
            surf_stride_q <= surf_stride_d;
            atom_q        <= atom_d;
            line_q        <= line_d;
            surf_q        <= surf_d;
            line_addr_q   <= line_addr_d;
            surf_addr_q   <= surf_addr_d;
            req_vld_q     <= req_vld_d;
            addr_q        <= addr_d;
            size_m1_q     <= size_m1_d;
            flags_q       <= flags_d;
            all_issued_q  <= all_issued_d;
            perf_q        <= perf_d;
        end
    end

    assign mcif_req_valid  = req_vld_q && (ram_type_q == RAM_MCIF);
    assign cvif_req_valid  = req_vld_q && (ram_type_q == RAM_CVIF);
    assign req_pd          = {size_m1_q, addr_q};
    // The context entry is pushed only in the accept cycle, so a stalled request never pushes twice.
    assign cq_valid        = accept;
    assign cq_pd           = {size_m1_q, flags_q};
    assign done            = (state_q == DRAIN) && credits_full;
    assign busy            = (state_q != IDLE) && !done;
    assign perf_read_stall = perf_q;

endmodule

// File: tb/tb_nvdla_rdma_req_engine.sv
// Scoreboard bench for nvdla_rdma_req_engine: a cube-walk model queues expected requests,
// a negedge monitor pops and compares them on each accepted request.
module tb_nvdla_rdma_req_engine;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_en = 1'b0;
    logic [63:0] cfg_base_addr = '0, cfg_line_stride = '0, cfg_surf_stride = '0;
    logic [12:0] cfg_width = '0, cfg_height = '0, cfg_surfaces = '0;
    logic        cfg_ram_type = 1'b1;
    logic        mcif_req_valid, cvif_req_valid, cq_valid, busy, done;
    logic        mcif_req_ready = 1'b1, cvif_req_ready = 1'b1, cq_ready = 1'b1, cdt_pop = 1'b0;
    logic [66:0] req_pd;
    logic [5:0]  cq_pd;
    logic [31:0] perf_read_stall;

    nvdla_rdma_req_engine #(.LAT_DEPTH(LAT)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rst  (rst),
        .op_en           (op_en),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_line_stride (cfg_line_stride),
        .cfg_surf_stride (cfg_surf_stride),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_surfaces    (cfg_surfaces),
        .cfg_ram_type    (cfg_ram_type),
        .mcif_req_valid  (mcif_req_valid),
        .mcif_req_ready  (mcif_req_ready),
        .cvif_req_valid  (cvif_req_valid),
        .cvif_req_ready  (cvif_req_ready),
        .req_pd          (req_pd),
        .cq_valid        (cq_valid),
        .cq_ready        (cq_ready),
        .cq_pd           (cq_pd),
        .cdt_pop         (cdt_pop),
        .busy            (busy),
        .done            (done),
        .perf_read_stall (perf_read_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size_m1;
        logic [2:0]  flags;
        logic        iface;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   accepts = 0, done_cnt = 0, mcif_cycles = 0, cvif_cycles = 0, cq_push_cnt = 0;
    int   outstanding = 0;
    bit   auto_pop = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference walk: plain loops and multiplies, independent of the accumulator datapath.
    task automatic push_cube(input logic [63:0] base, ls, ss, input int w, h, s, input logic ram);
        exp_t e;
        for (int si = 0; si <= s; si++) begin
            for (int li = 0; li <= h; li++) begin
                int a = 0;
                while (a <= w) begin
                    int  sz;
                    logic le, se, ce;
                    sz = (w + 1 - a > 8) ? 8 : w + 1 - a;
                    le = (a + sz > w);
                    se = le && (li == h);
                    ce = se && (si == s);
                    e.addr    = base + 64'(si) * ss + 64'(li) * ls + 64'(a) * 64'd32;
                    e.size_m1 = 3'(sz - 1);
                    e.flags   = {le, se, ce};
                    e.iface   = ram;
                    exp_q.push_back(e);
                    a += sz;
                end
            end
        end
    endtask

    task automatic start_op(input logic [63:0] base, ls, ss, input int w, h, s, input logic ram);
        @(posedge clk); #1;
        cfg_base_addr   = base;
        cfg_line_stride = ls;
        cfg_surf_stride = ss;
        cfg_width       = 13'(w);
        cfg_height      = 13'(h);
        cfg_surfaces    = 13'(s);
        cfg_ram_type    = ram;
        op_en           = 1'b1;
        push_cube(base, ls, ss, w, h, s, ram);
        @(posedge clk); #1;
        op_en = 1'b0;
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cdt_pop = 1'b1;
            outstanding--;
        end
        @(posedge clk); #1;
        cdt_pop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) begin
            @(negedge clk); #1;
        end
        check({tag, "_done_seen"}, done_cnt != start, 1'b1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (auto_pop) begin
            if (outstanding > 0) begin
                cdt_pop = 1'b1;
                outstanding--;
            end else begin
                cdt_pop = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic acc_m, acc_c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc_m = mcif_req_valid && mcif_req_ready;
                acc_c = cvif_req_valid && cvif_req_ready;
                if (mcif_req_valid) mcif_cycles++;
                if (cvif_req_valid) cvif_cycles++;
                if (done) done_cnt++;
                if (cq_valid && cq_ready) cq_push_cnt++;
                if (mcif_req_valid || cvif_req_valid)
                    check("if_exclusive", mcif_req_valid && cvif_req_valid, 1'b0);
                if (cq_valid || acc_m || acc_c)
                    check("cq_valid_on_accept", cq_valid, acc_m || acc_c);
                if (acc_m || acc_c) begin
                    accepts++;
                    check("sb_has_entry", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("req_addr", req_pd[63:0], e.addr);
                        check("req_size", req_pd[66:64], e.size_m1);
                        check("cq_size", cq_pd[5:3], e.size_m1);
                        check("cq_flags", cq_pd[2:0], e.flags);
                        check("req_iface", acc_m, e.iface);
                        outstanding += int'(e.size_m1) + 1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int a0, d0, m0, q0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mcif_valid", mcif_req_valid, 1'b0);
        check("rst_cvif_valid", cvif_req_valid, 1'b0);
        check("rst_cq_valid", cq_valid, 1'b0);
        check("rst_req_pd", req_pd, 67'd0);
        check("rst_cq_pd", cq_pd, 6'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_perf", perf_read_stall, 32'd0);
        check("rst_credits", dut.u_credit.credits, LAT);
        @(posedge clk); #1;
        rst = 1'b0;

        // Walk: 20 atoms in one line -> 8, 8, 4
        auto_pop = 1'b1;
        a0 = accepts; d0 = done_cnt;
        start_op(64'h1000, 64'h0, 64'h0, 19, 0, 0, 1'b1);
        check("walk_busy", busy, 1'b1);
        wait_done("walk", 300);
        repeat (3) @(negedge clk);
        check("walk_accepts", accepts - a0, 3);
        check("walk_done_pulses", done_cnt - d0, 1);
        check("walk_sb_empty", exp_q.size(), 0);
        check("walk_busy_after", busy, 1'b0);
        check("walk_credits", dut.u_credit.credits, LAT);

        // Strides on CVIF
        a0 = accepts; m0 = mcif_cycles;
        start_op(64'h0, 64'h80, 64'h400, 0, 1, 1, 1'b0);
        wait_done("stride", 300);
        check("stride_accepts", accepts - a0, 4);
        check("stride_mcif_quiet", mcif_cycles - m0, 0);
        check("stride_sb_empty", exp_q.size(), 0);

        // Credit gating with LAT_DEPTH=16, 32 atoms
        auto_pop = 1'b0;
        a0 = accepts;
        start_op(64'h2000, 64'h0, 64'h0, 31, 0, 0, 1'b1);
        repeat (20) @(negedge clk);
        check("credit_two_issued", accepts - a0, 2);
        check("credit_stalled", mcif_req_valid, 1'b0);
        pop_n(1);
        repeat (10) @(negedge clk);
        check("credit_one_pop_stall", accepts - a0, 2);
        pop_n(7);
        repeat (10) @(negedge clk);
        check("credit_third_issued", accepts - a0, 3);
        auto_pop = 1'b1;
        wait_done("credit", 300);
        check("credit_accepts", accepts - a0, 4);

        // Backpressure: ready low for 5 cycles on the first request
        mcif_req_ready = 1'b0;
        a0 = accepts; q0 = cq_push_cnt;
        start_op(64'h3000, 64'h0, 64'h0, 7, 0, 0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", mcif_req_valid, 1'b1);
            check("bp_req_pd_stable", req_pd, {3'd7, 64'h3000});
            @(posedge clk);
        end
        #1 mcif_req_ready = 1'b1;
        wait_done("bp", 100);
        check("bp_perf_stall", perf_read_stall, 32'd5);
        check("bp_cq_once", cq_push_cnt - q0, 1);
        check("bp_accepts", accepts - a0, 1);

        // Simultaneous accept and pop with credits=10; op_en while busy
        auto_pop = 1'b0;
        mcif_req_ready = 1'b0;
        a0 = accepts; d0 = done_cnt; m0 = cvif_cycles;
        start_op(64'h4000, 64'h0, 64'h0, 15, 0, 0, 1'b1);
        mcif_req_ready = 1'b1;
        @(posedge clk); #1;
        mcif_req_ready = 1'b0;
        pop_n(2);
        mcif_req_ready = 1'b1;
        cdt_pop = 1'b1;
        outstanding--;
        @(posedge clk); #1;
        mcif_req_ready = 1'b0;
        cdt_pop = 1'b0;
        @(negedge clk);
        check("sim_credits", dut.u_credit.credits, 3);
        @(posedge clk); #1;
        cfg_width = 13'd0; cfg_ram_type = 1'b0; cfg_base_addr = 64'h9000;
        op_en = 1'b1;
        @(posedge clk); #1;
        op_en = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_op_en_ignored", accepts - a0, 2);
        check("busy_op_en_no_cvif", cvif_cycles - m0, 0);
        check("busy_cfg_held", dut.width_q, 13'd15);
        check("busy_still", busy, 1'b1);
        pop_n(12);
        repeat (3) @(negedge clk);
        check("sim_no_early_done", done_cnt - d0, 0);
        pop_n(1);
        wait_done("sim", 20);
        mcif_req_ready = 1'b1;

        // Degenerate cube
        auto_pop = 1'b1;
        a0 = accepts;
        start_op(64'h0, 64'h0, 64'h0, 0, 0, 0, 1'b1);
        wait_done("degen", 100);
        check("degen_accepts", accepts - a0, 1);
        check("degen_sb_empty", exp_q.size(), 0);

        // Reset mid-operation
        auto_pop = 1'b0;
        mcif_req_ready = 1'b0;
        start_op(64'h6000, 64'h0, 64'h0, 31, 0, 0, 1'b1);
        mcif_req_ready = 1'b1;
        @(posedge clk); #1;
        mcif_req_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_credits", dut.u_credit.credits, 8);
        rst = 1'b1;
        exp_q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        a0 = accepts; d0 = done_cnt;
        check("midrst_mcif_valid", mcif_req_valid, 1'b0);
        check("midrst_cq_valid", cq_valid, 1'b0);
        check("midrst_req_pd", req_pd, 67'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_perf", perf_read_stall, 32'd0);
        check("midrst_credits", dut.u_credit.credits, LAT);
        rst = 1'b0;
        mcif_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_no_done", done_cnt - d0, 0);
        check("postrst_no_req", accepts - a0, 0);
        check("postrst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
